stream_demux: RTL and testbench

//  Packet-mode 1-to-2 AXI-Stream demultiplexer; counterpart of the cell-link stream mux.

---
 rtl/stream_demux_pkg.sv | 18 +
 rtl/stream_demux_axis_reg_slice.sv | 39 +++
 rtl/stream_demux.sv | 131 +++++++++++++
 tb/tb_stream_demux.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the packet-mode stream demultiplexer.
// Holds the FSM state encoding and the default stream geometry.
// Imported by the demux top and its register-slice sub-module.
package stream_demux_pkg;

  localparam int DW_DEF        = 33;
  localparam int TLAST_BIT_DEF = 32;
  localparam int ROUTE_BIT_DEF = 31;
  localparam int CW_DEF        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD0 = 2'd1,
    FWD1 = 2'd2,
    DROP = 2'd3
  } state_t;

endpackage

// File: rtl/stream_demux_axis_reg_slice.sv
// One-entry stream register slice with full-throughput ready.
// Latency: 1 cycle from accepted input word to m_valid.
// Backpressure: s_ready = slot empty or downstream ready; holds data stable until m_ready.
module axis_reg_slice
  import stream_demux_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);

  logic          full;
  logic [DW-1:0] data;

  assign s_ready = !full || m_ready;
  assign m_valid = full;
  assign m_data  = data;

  // Load on accepted input; otherwise empty once downstream takes the word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full <= 1'b0;
      data <= '0;
    end else if (s_valid && s_ready) begin
      full <= 1'b1;
      data <= s_data;
    end else if (m_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Packet-mode 1-to-2 stream demux: header ROUTE_BIT steers whole packets to m00/m01 or drops them.
// Latency: 1 cycle input-to-output through a per-port register slice.
// Backpressure: input ready follows the selected port's slice only; drop path always ready.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int TLAST_BIT = TLAST_BIT_DEF,
  parameter int ROUTE_BIT = ROUTE_BIT_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s00_tvalid,
  output logic          s00_tready,
  input  logic [DW-1:0] s00_tdata,
  output logic          m00_tvalid,
  input  logic          m00_tready,
  output logic [DW-1:0] m00_tdata,
  output logic          m01_tvalid,
  input  logic          m01_tready,
  output logic [DW-1:0] m01_tdata,
  input  logic          m00_enable,
  input  logic          m01_enable,
  output logic [CW-1:0] m00_pkt_count,
  output logic [CW-1:0] m01_pkt_count,
  output logic [CW-1:0] drop_count
);

  state_t state;
  logic   run;       // low during and for one cycle after reset; keeps input ready low in reset
  logic   s_last;
  logic   s_route;
  logic   hdr_en;
  logic   to0;
  logic   to1;
  logic   sel1;
  logic   rdy0;
  logic   rdy1;
  logic   acc;

  // Decode the current word and steer ready from the port this word belongs to.
  always_comb begin
    s_last  = s00_tdata[TLAST_BIT];
    s_route = s00_tdata[ROUTE_BIT];
    hdr_en  = s_route ? m01_enable : m00_enable;
    to0     = (state == FWD0) || ((state == IDLE) && !s_route && m00_enable);
    to1     = (state == FWD1) || ((state == IDLE) &&  s_route && m01_enable);
    sel1    = (state == FWD1) || ((state == IDLE) &&  s_route);
    if (!run) begin
      s00_tready = 1'b0;
    end else if (state == DROP) begin
      s00_tready = 1'b1;
    end else begin
      s00_tready = sel1 ? rdy1 : rdy0;
    end
    acc = s00_tvalid && s00_tready;
  end

  axis_reg_slice #(.DW(DW)) u_slice0 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (acc && to0),
    .s_ready (rdy0),
    .s_data  (s00_tdata),
    .m_valid (m00_tvalid),
    .m_ready (m00_tready),
    .m_data  (m00_tdata)
  );

  axis_reg_slice #(.DW(DW)) u_slice1 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (acc && to1),
    .s_ready (rdy1),
    .s_data  (s00_tdata),
    .m_valid (m01_tvalid),
    .m_ready (m01_tready),
    .m_data  (m01_tdata)
  );

  // Packet FSM: route/enable are sampled on the header only; TLAST closes the packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      run        <= 1'b0;
      drop_count <= '0;
    end else begin
      run <= 1'b1;
      if (acc) begin
        case (state)
          IDLE: begin
            if (!s_last) begin
              state <= hdr_en ? (s_route ? FWD1 : FWD0) : DROP;
            end else if (!hdr_en && (drop_count != '1)) begin
              drop_count <= drop_count + CW'(1);
            end
          end
          FWD0, FWD1: begin
            if (s_last) state <= IDLE;
          end
          DROP: begin
            if (s_last) begin
              state <= IDLE;
              if (drop_count != '1) drop_count <= drop_count + CW'(1);
            end
          end
        endcase
      end
    end
  end

  // Saturating count of packets whose last word left on m00.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m00_pkt_count <= '0;
    end else if (m00_tvalid && m00_tready && m00_tdata[TLAST_BIT] && (m00_pkt_count != '1)) begin
      m00_pkt_count <= m00_pkt_count + CW'(1);
    end
  end

  // Saturating count of packets whose last word left on m01.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m01_pkt_count <= '0;
    end else if (m01_tvalid && m01_tready && m01_tdata[TLAST_BIT] && (m01_pkt_count != '1)) begin
      m01_pkt_count <= m01_pkt_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: table of per-cycle vectors plus hand sequences
// for backpressure isolation, mid-packet reset and counter saturation.
// A second instance with a 4-bit counter exercises saturation.
module tb_stream_demux;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_vld, s_rdy;
  logic [32:0] s_dat;
  logic        m0_vld, m0_rdy, m1_vld, m1_rdy;
  logic [32:0] m0_dat, m1_dat;
  logic        en0, en1;
  logic [15:0] c0, c1, cd;

  logic        sat_vld, sat_rdy, sat_m0_vld, sat_m1_vld;
  logic [32:0] sat_dat, sat_m0_dat, sat_m1_dat;
  logic [3:0]  sat_c0, sat_c1, sat_cd;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  stream_demux dut (
    .aclk(aclk), .aresetn(aresetn),
    .s00_tvalid(s_vld), .s00_tready(s_rdy), .s00_tdata(s_dat),
    .m00_tvalid(m0_vld), .m00_tready(m0_rdy), .m00_tdata(m0_dat),
    .m01_tvalid(m1_vld), .m01_tready(m1_rdy), .m01_tdata(m1_dat),
    .m00_enable(en0), .m01_enable(en1),
    .m00_pkt_count(c0), .m01_pkt_count(c1), .drop_count(cd)
  );

  stream_demux #(.CW(4)) dut_sat (
    .aclk(aclk), .aresetn(aresetn),
    .s00_tvalid(sat_vld), .s00_tready(sat_rdy), .s00_tdata(sat_dat),
    .m00_tvalid(sat_m0_vld), .m00_tready(1'b1), .m00_tdata(sat_m0_dat),
    .m01_tvalid(sat_m1_vld), .m01_tready(1'b1), .m01_tdata(sat_m1_dat),
    .m00_enable(1'b1), .m01_enable(1'b1),
    .m00_pkt_count(sat_c0), .m01_pkt_count(sat_c1), .drop_count(sat_cd)
  );

  typedef struct {
    logic        vld;
    logic [32:0] dat;
    logic        en1;
    logic        x_srdy;
    logic        x_v0;
    logic [32:0] x_d0;
    logic        x_v1;
    logic [32:0] x_d1;
    logic [15:0] x_c0;
    logic [15:0] x_c1;
    logic [15:0] x_cd;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic vld, input logic [32:0] dat, input logic e1,
                              input logic srdy, input logic v0, input logic [32:0] d0,
                              input logic v1, input logic [32:0] d1,
                              input int k0, input int k1, input int kd);
    vec_t v;
    v.vld = vld; v.dat = dat; v.en1 = e1; v.x_srdy = srdy;
    v.x_v0 = v0; v.x_d0 = d0; v.x_v1 = v1; v.x_d1 = d1;
    v.x_c0 = 16'(k0); v.x_c1 = 16'(k1); v.x_cd = 16'(kd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the clock edge, then wait to the sampling edge.
  task automatic drive(input logic vld, input logic [32:0] dat, input logic e0, input logic e1,
                       input logic r0, input logic r1);
    @(posedge aclk); #1;
    s_vld = vld; s_dat = dat; en0 = e0; en1 = e1; m0_rdy = r0; m1_rdy = r1;
    @(negedge aclk);
  endtask

  initial begin
    aresetn = 1'b0;
    s_vld = 1'b0; s_dat = '0; en0 = 1'b1; en1 = 1'b1; m0_rdy = 1'b1; m1_rdy = 1'b1;
    sat_vld = 1'b0; sat_dat = '0;

    // single-word and multi-word to m00, back-to-back singles to m01, dropped packet
    tbl[0]  = mk(1, 33'h0_0000_0010, 1, 1, 0, 0,              0, 0,              0, 0, 0);
    tbl[1]  = mk(1, 33'h0_0000_0001, 1, 1, 1, 33'h0_0000_0010, 0, 0,              0, 0, 0);
    tbl[2]  = mk(1, 33'h1_0000_0002, 1, 1, 1, 33'h0_0000_0001, 0, 0,              0, 0, 0);
    tbl[3]  = mk(0, 33'h0,           1, 1, 1, 33'h1_0000_0002, 0, 0,              0, 0, 0);
    tbl[4]  = mk(0, 33'h0,           1, 1, 0, 0,              0, 0,              1, 0, 0);
    tbl[5]  = mk(1, 33'h1_8000_00A1, 1, 1, 0, 0,              0, 0,              1, 0, 0);
    tbl[6]  = mk(1, 33'h1_8000_00A2, 1, 1, 0, 0,              1, 33'h1_8000_00A1, 1, 0, 0);
    tbl[7]  = mk(1, 33'h1_8000_00A3, 1, 1, 0, 0,              1, 33'h1_8000_00A2, 1, 1, 0);
    tbl[8]  = mk(1, 33'h1_8000_00A4, 1, 1, 0, 0,              1, 33'h1_8000_00A3, 1, 2, 0);
    tbl[9]  = mk(0, 33'h0,           1, 1, 0, 0,              1, 33'h1_8000_00A4, 1, 3, 0);
    tbl[10] = mk(0, 33'h0,           1, 1, 0, 0,              0, 0,              1, 4, 0);
    tbl[11] = mk(1, 33'h0_8000_0000, 0, 1, 0, 0,              0, 0,              1, 4, 0);
    tbl[12] = mk(1, 33'h0_0000_0002, 0, 1, 0, 0,              0, 0,              1, 4, 0);
    tbl[13] = mk(1, 33'h0_0000_0003, 1, 1, 0, 0,              0, 0,              1, 4, 0);
    tbl[14] = mk(1, 33'h0_0000_0004, 1, 1, 0, 0,              0, 0,              1, 4, 0);
    tbl[15] = mk(1, 33'h1_0000_0005, 1, 1, 0, 0,              0, 0,              1, 4, 0);
    tbl[16] = mk(0, 33'h0,           1, 1, 0, 0,              0, 0,              1, 4, 1);

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_rdy", s_rdy, 0);
    chk("rst_m0_vld", m0_vld, 0);
    chk("rst_m1_vld", m1_vld, 0);
    chk("rst_m0_dat", m0_dat, 0);
    chk("rst_counts", {c0, c1, cd}, 0);
    aresetn = 1'b1;
    @(posedge aclk);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].dat, 1'b1, tbl[i].en1, 1'b1, 1'b1);
      chk($sformatf("v%0d_s_rdy", i), s_rdy, tbl[i].x_srdy);
      chk($sformatf("v%0d_m0_vld", i), m0_vld, tbl[i].x_v0);
      chk($sformatf("v%0d_m1_vld", i), m1_vld, tbl[i].x_v1);
      if (tbl[i].x_v0) chk($sformatf("v%0d_m0_dat", i), m0_dat, tbl[i].x_d0);
      if (tbl[i].x_v1) chk($sformatf("v%0d_m1_dat", i), m1_dat, tbl[i].x_d1);
      chk($sformatf("v%0d_m00_cnt", i), c0, tbl[i].x_c0);
      chk($sformatf("v%0d_m01_cnt", i), c1, tbl[i].x_c1);
      chk($sformatf("v%0d_drop_cnt", i), cd, tbl[i].x_cd);
    end

    // m00 stalled for 10 cycles while a word already in m01's slot drains
    drive(1, 33'h1_8000_00B1, 1, 1, 0, 0);
    chk("bp_a_s_rdy", s_rdy, 1);
    drive(1, 33'h0_0000_0020, 1, 1, 0, 0);
    chk("bp_b_s_rdy", s_rdy, 1);
    chk("bp_b_m1_dat", m1_dat, 33'h1_8000_00B1);
    drive(1, 33'h0_0000_0021, 1, 1, 0, 1);
    chk("bp_c_s_rdy", s_rdy, 0);
    chk("bp_c_m0_dat", m0_dat, 33'h0_0000_0020);
    chk("bp_c_m1_vld", m1_vld, 1);
    for (int i = 0; i < 9; i++) begin
      drive(1, 33'h0_0000_0021, 1, 1, 0, 1);
      chk($sformatf("bp_hold%0d_s_rdy", i), s_rdy, 0);
      chk($sformatf("bp_hold%0d_m0", i), {m0_vld, m0_dat}, {1'b1, 33'h0_0000_0020});
      chk($sformatf("bp_hold%0d_m1_vld", i), m1_vld, 0);
    end
    chk("bp_m01_cnt", c1, 5);
    drive(1, 33'h0_0000_0021, 1, 1, 1, 1);
    chk("bp_d_s_rdy", s_rdy, 1);
    drive(1, 33'h1_0000_0022, 1, 1, 1, 1);
    chk("bp_e_m0_dat", m0_dat, 33'h0_0000_0021);
    drive(0, 33'h0, 1, 1, 1, 1);
    chk("bp_f_m0_dat", m0_dat, 33'h1_0000_0022);
    drive(0, 33'h0, 1, 1, 1, 1);
    chk("bp_m00_cnt", c0, 2);
    chk("bp_m0_idle", m0_vld, 0);

    // reset during word 2 of a packet to m00
    drive(1, 33'h0_0000_0030, 1, 1, 1, 1);
    chk("mr_hdr_s_rdy", s_rdy, 1);
    @(posedge aclk); #1;
    s_dat = 33'h0_0000_0031;
    chk("mr_pre_m0_vld", m0_vld, 1);
    aresetn = 1'b0;
    #1;
    chk("mr_m0_vld", m0_vld, 0);
    chk("mr_m1_vld", m1_vld, 0);
    chk("mr_s_rdy", s_rdy, 0);
    chk("mr_counts", {c0, c1, cd}, 0);
    s_vld = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    drive(1, 33'h1_8000_0040, 1, 1, 1, 1);
    chk("mr_new_s_rdy", s_rdy, 1);
    drive(0, 33'h0, 1, 1, 1, 1);
    chk("mr_new_m1", {m1_vld, m1_dat}, {1'b1, 33'h1_8000_0040});
    chk("mr_new_m0_vld", m0_vld, 0);
    drive(0, 33'h0, 1, 1, 1, 1);
    chk("mr_new_counts", {c0, c1}, {16'd0, 16'd1});

    // saturation of a 4-bit counter
    for (int i = 0; i < 15; i++) begin
      @(posedge aclk); #1;
      sat_vld = 1'b1;
      sat_dat = 33'h1_0000_0000 | 33'(i);
    end
    @(posedge aclk); #1;
    sat_vld = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("sat_15", sat_c0, 15);
    @(posedge aclk); #1;
    sat_vld = 1'b1;
    sat_dat = 33'h1_0000_0010;
    @(posedge aclk); #1;
    sat_vld = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("sat_16", sat_c0, 15);
    chk("sat_drop", sat_cd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
